// File: rtl/umi_memtest_initiator_if.sv
// UMI request/response channel pair between the memtest initiator and a UMI device.
interface umi_memtest_initiator_if #(
    parameter int DW = 256,
    parameter int AW = 64,
    parameter int CW = 32
);
    logic          udev_req_valid;
    logic          udev_req_ready;
    logic [CW-1:0] udev_req_cmd;
    logic [AW-1:0] udev_req_dstaddr;
    logic [AW-1:0] udev_req_srcaddr;
    logic [DW-1:0] udev_req_data;
    logic          udev_resp_valid;
    logic          udev_resp_ready;
    logic [CW-1:0] udev_resp_cmd;
    logic [AW-1:0] udev_resp_dstaddr;
    logic [AW-1:0] udev_resp_srcaddr;
    logic [DW-1:0] udev_resp_data;

    modport master (
        output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
               udev_req_data, udev_resp_ready,
        input  udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
               udev_resp_srcaddr, udev_resp_data
    );

    modport slave (
        input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
               udev_req_data, udev_resp_ready,
        output udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
               udev_resp_srcaddr, udev_resp_data
    );
endinterface

// File: rtl/umi_memtest_initiator.sv
// Host-side UMI initiator: writes a SEED+i pattern to N words, reads them back
// with bounded outstanding reads and reports pass/fail, error count and first bad address.
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_WRITE | posting write i = idx_q
// S_READ  | issuing read i = idx_q while outstanding < MAX_OUT
// S_DRAIN | all reads issued, waiting for outstanding responses
// S_DONE  | result valid, waiting for the next start
module umi_memtest_initiator #(
    parameter int             DW        = 256,
    parameter int             AW        = 64,
    parameter int             CW        = 32,
    parameter int             N         = 16,
    parameter logic [AW-1:0]  BASE      = '0,
    parameter logic [AW-1:0]  RESP_ADDR = 64'h1000,
    parameter logic [31:0]    SEED      = 32'hA5A5_0000,
    parameter int             MAX_OUT   = 4,
    parameter logic [7:0]     OPC_WRITE = 8'h01,
    parameter logic [7:0]     OPC_READ  = 8'h02,
    parameter logic [7:0]     OPC_RESP  = 8'h03
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [AW-1:0]           first_err_addr,
    umi_memtest_initiator_if.master udev
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] LAST = 16'(N - 1);
    localparam logic [3:0]  MAXO = 4'(MAX_OUT);

    state_t        state_q, state_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   ridx_q, ridx_d;
    logic [15:0]   err_q, err_d;
    logic [3:0]    out_q, out_d;
    logic [AW-1:0] ferr_q, ferr_d;
    logic          resp_ready_q, resp_ready_d;

    logic          req_hs, rd_hs, resp_hs, resp_ok, in_check;
    logic [31:0]   pattern, resp_pat;
    logic [AW-1:0] word_addr, resp_addr;
    logic          unused_ok;

    assign unused_ok = ^{udev.udev_resp_srcaddr, udev.udev_resp_cmd[CW-1:8],
                         udev.udev_resp_data[DW-1:32]};

    // Payload is a pure function of state and index, so it holds steady while stalled.
    always_comb begin
        pattern   = SEED + 32'(idx_q);
        word_addr = BASE + (AW'(idx_q) << 2);
        udev.udev_req_valid   = (state_q == S_WRITE) || ((state_q == S_READ) && (out_q < MAXO));
        udev.udev_req_cmd     = '0;
        udev.udev_req_dstaddr = '0;
        udev.udev_req_srcaddr = '0;
        udev.udev_req_data    = '0;
        if (udev.udev_req_valid) begin
            udev.udev_req_cmd[11:8] = 4'd2;
            udev.udev_req_cmd[7:0]  = (state_q == S_WRITE) ? OPC_WRITE : OPC_READ;
            udev.udev_req_dstaddr   = word_addr;
            udev.udev_req_srcaddr   = RESP_ADDR;
            if (state_q == S_WRITE) udev.udev_req_data = {(DW/32){pattern}};
        end
        udev.udev_resp_ready = resp_ready_q;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ridx_d       = ridx_q;
        err_d        = err_q;
        out_d        = out_q;
        ferr_d       = ferr_q;
        resp_ready_d = 1'b1;

        req_hs    = udev.udev_req_valid && udev.udev_req_ready;
        rd_hs     = req_hs && (state_q == S_READ);
        resp_hs   = udev.udev_resp_valid && resp_ready_q;
        in_check  = (state_q == S_READ) || (state_q == S_DRAIN);
        resp_pat  = SEED + 32'(ridx_q);
        resp_addr = BASE + (AW'(ridx_q) << 2);
        resp_ok   = (udev.udev_resp_cmd[7:0] == OPC_RESP) &&
                    (udev.udev_resp_dstaddr == RESP_ADDR) &&
                    (udev.udev_resp_data[31:0] == resp_pat);

        if (resp_hs) begin
            if (in_check) begin
                ridx_d = ridx_q + 16'd1;
                if (out_q != 4'd0) out_d = out_q - 4'd1;
            end
            if (!in_check || !resp_ok) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                if (err_q == 16'd0) ferr_d = in_check ? resp_addr : '0;
            end
        end
        if (rd_hs) out_d = out_d + 4'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                    ridx_d  = '0;
                    err_d   = '0;
                    out_d   = '0;
                    ferr_d  = '0;
                end
            end
            S_WRITE: begin
                if (req_hs) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == LAST) begin
                        state_d = S_READ;
                        idx_d   = '0;
                    end
                end
            end
            S_READ: begin
                if (req_hs) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == LAST) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (out_q == 4'd0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            ridx_q       <= '0;
            err_q        <= '0;
            out_q        <= '0;
            ferr_q       <= '0;
            resp_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ridx_q       <= ridx_d;
            err_q        <= err_d;
            out_q        <= out_d;
            ferr_q       <= ferr_d;
            resp_ready_q <= resp_ready_d;
        end
    end

    assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = (state_q == S_DONE) && (err_q == 16'd0);
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_umi_memtest_initiator.sv
// Bench for umi_memtest_initiator: a behavioural UMI memory with random stalls,
// latency, corruption and injected responses, checked against the expected request stream.
module tb_umi_memtest_initiator;
    localparam int            DW        = 256;
    localparam int            AW        = 64;
    localparam int            CW        = 32;
    localparam int            N         = 8;
    localparam int            MAX_OUT   = 4;
    localparam logic [AW-1:0] BASE      = 64'h200;
    localparam logic [AW-1:0] RESP_ADDR = 64'h1000;
    localparam logic [31:0]   SEED      = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    umi_memtest_initiator_if #(.DW(DW), .AW(AW), .CW(CW)) udev ();

    umi_memtest_initiator #(
        .DW(DW), .AW(AW), .CW(CW), .N(N), .BASE(BASE), .RESP_ADDR(RESP_ADDR),
        .SEED(SEED), .MAX_OUT(MAX_OUT), .OPC_WRITE(8'h01), .OPC_READ(8'h02), .OPC_RESP(8'h03)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .udev(udev)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    opc;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [31:0]   word;
        int            rel;
        bit            is_read;
    } rsp_t;

    int n_checks = 0;
    int n_errors = 0;

    // scenario controls (written by the main sequence only)
    int            rmode, lat_max, clr_cnt, inj_cnt;
    bit            hold_en;
    logic [N-1:0]  cmask;
    int            ctype [N];

    // memory model state (written by the device process only)
    int            cyc, writes_seen, reads_seen, model_out, max_out_seen;
    int            hold_until, last_rel, clr_seen, inj_seen;
    rsp_t          rq [$];
    logic [31:0]   mem [logic [AW-1:0]];
    logic          stall_prev;
    logic [CW-1:0] p_cmd;
    logic [AW-1:0] p_dst, p_src;
    logic [DW-1:0] p_data;
    event          sampled;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        rq.delete();
        mem.delete();
        writes_seen  = 0;
        reads_seen   = 0;
        model_out    = 0;
        max_out_seen = 0;
        hold_until   = 0;
        last_rel     = 0;
        stall_prev   = 1'b0;
    endtask

    task automatic dev_req();
        int            i;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rsp_t          r;
        wr = (writes_seen < N);
        if (!wr && reads_seen >= N) begin
            chk("extra_req", DW'(udev.udev_req_valid), DW'(1'b0));
            return;
        end
        i = wr ? writes_seen : reads_seen;
        a = BASE + AW'(4 * i);
        d = wr ? {(DW/32){SEED + 32'(i)}} : '0;
        chk(wr ? "wr_cmd" : "rd_cmd", DW'(udev.udev_req_cmd), DW'({20'd0, 4'd2, wr ? 8'h01 : 8'h02}));
        chk(wr ? "wr_dst" : "rd_dst", DW'(udev.udev_req_dstaddr), DW'(a));
        chk("req_src", DW'(udev.udev_req_srcaddr), DW'(RESP_ADDR));
        chk(wr ? "wr_data" : "rd_data", udev.udev_req_data, d);
        if (wr) begin
            mem[a] = SEED + 32'(i);
            writes_seen++;
        end else begin
            r.opc     = 8'h03;
            r.dst     = RESP_ADDR;
            r.src     = a;
            r.word    = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
            r.is_read = 1'b1;
            if (cmask[i]) begin
                case (ctype[i])
                    0:       r.word = r.word ^ 32'h0000_0100;
                    1:       r.opc  = 8'h04;
                    default: r.dst  = RESP_ADDR + 64'h4;
                endcase
            end
            if (hold_en && hold_until == 0) hold_until = cyc + 20;
            r.rel = cyc + int'($urandom_range(1, lat_max));
            if (r.rel < hold_until) r.rel = hold_until;
            if (r.rel < last_rel) r.rel = last_rel;
            last_rel = r.rel;
            rq.push_back(r);
            reads_seen++;
            model_out++;
        end
    endtask

    task automatic dev_sample();
        logic v, hs, rhs;
        v = udev.udev_req_valid;
        if (stall_prev) begin
            chk("stall_valid", DW'(v), DW'(1'b1));
            chk("stall_cmd", DW'(udev.udev_req_cmd), DW'(p_cmd));
            chk("stall_dst", DW'(udev.udev_req_dstaddr), DW'(p_dst));
            chk("stall_src", DW'(udev.udev_req_srcaddr), DW'(p_src));
            chk("stall_data", udev.udev_req_data, p_data);
        end
        if (writes_seen == N && reads_seen < N)
            chk("rd_flow", DW'(v), DW'(model_out < MAX_OUT));
        hs  = v && udev.udev_req_ready;
        rhs = udev.udev_resp_valid && udev.udev_resp_ready;
        if (rhs && rq.size() > 0) begin
            if (rq[0].is_read) model_out--;
            rq.delete(0);
        end
        if (hs) dev_req();
        stall_prev = v && !udev.udev_req_ready;
        p_cmd  = udev.udev_req_cmd;
        p_dst  = udev.udev_req_dstaddr;
        p_src  = udev.udev_req_srcaddr;
        p_data = udev.udev_req_data;
        if (model_out > max_out_seen) max_out_seen = model_out;
    endtask

    // Device model: drives ready/response just after each rising edge, samples at the falling edge.
    initial begin : device
        rsp_t r;
        cyc = 0; clr_seen = 0; inj_seen = 0;
        model_clear();
        udev.udev_req_ready    = 1'b0;
        udev.udev_resp_valid   = 1'b0;
        udev.udev_resp_cmd     = '0;
        udev.udev_resp_dstaddr = '0;
        udev.udev_resp_srcaddr = '0;
        udev.udev_resp_data    = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst || clr_cnt != clr_seen) begin
                clr_seen = clr_cnt;
                model_clear();
            end
            if (inj_cnt != inj_seen) begin
                inj_seen  = inj_cnt;
                r.opc     = 8'h03;
                r.dst     = RESP_ADDR;
                r.src     = BASE;
                r.word    = SEED;
                r.rel     = 0;
                r.is_read = 1'b0;
                rq.push_back(r);
            end
            case (rmode)
                0:       udev.udev_req_ready = !rst;
                1:       udev.udev_req_ready = !rst && cyc[0];
                default: udev.udev_req_ready = !rst && ($urandom_range(0, 1) == 1);
            endcase
            if (!rst && rq.size() > 0 && rq[0].rel <= cyc) begin
                udev.udev_resp_valid   = 1'b1;
                udev.udev_resp_cmd     = {20'd0, 4'd2, rq[0].opc};
                udev.udev_resp_dstaddr = rq[0].dst;
                udev.udev_resp_srcaddr = rq[0].src;
                udev.udev_resp_data    = {(DW/32){rq[0].word}};
            end else begin
                udev.udev_resp_valid   = 1'b0;
                udev.udev_resp_cmd     = '0;
                udev.udev_resp_dstaddr = '0;
                udev.udev_resp_srcaddr = '0;
                udev.udev_resp_data    = '0;
            end
            @(negedge clk);
            if (!rst) dev_sample();
            -> sampled;
        end
    end

    task automatic reset_outputs_chk(input string pfx);
        chk({pfx, "_busy"}, DW'(busy), DW'(1'b0));
        chk({pfx, "_done"}, DW'(done), DW'(1'b0));
        chk({pfx, "_pass"}, DW'(pass), DW'(1'b0));
        chk({pfx, "_err"}, DW'(err_count), DW'(16'd0));
        chk({pfx, "_first"}, DW'(first_err_addr), DW'(64'd0));
        chk({pfx, "_req_valid"}, DW'(udev.udev_req_valid), DW'(1'b0));
        chk({pfx, "_resp_ready"}, DW'(udev.udev_resp_ready), DW'(1'b0));
        chk({pfx, "_req_cmd"}, DW'(udev.udev_req_cmd), DW'(32'd0));
        chk({pfx, "_req_data"}, udev.udev_req_data, '0);
    endtask

    task automatic start_run(input int rm, input int lm, input bit hold, input logic [N-1:0] cm);
        rmode   = rm;
        lat_max = lm;
        hold_en = hold;
        cmask   = cm;
        for (int i = 0; i < N; i++) ctype[i] = int'($urandom_range(0, 2));
        clr_cnt++;
        @(posedge clk); #2;
        chk("resp_ready", DW'(udev.udev_resp_ready), DW'(1'b1));
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("start_busy", DW'(busy), DW'(1'b1));
        chk("start_done", DW'(done), DW'(1'b0));
        chk("start_valid", DW'(udev.udev_req_valid), DW'(1'b1));
        chk("start_dst", DW'(udev.udev_req_dstaddr), DW'(BASE));
        chk("start_err_clear", DW'(err_count), DW'(16'd0));
    endtask

    task automatic finish_run();
        int            k;
        logic [15:0]   e_err;
        logic [AW-1:0] e_first;
        e_err   = 16'($countones(cmask));
        e_first = '0;
        for (int i = N - 1; i >= 0; i--) if (cmask[i]) e_first = BASE + AW'(4 * i);
        k = 0;
        while (!done && k < 3000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("done", DW'(done), DW'(1'b1));
        chk("busy_at_done", DW'(busy), DW'(1'b0));
        chk("pass", DW'(pass), DW'(e_err == 16'd0));
        chk("err_count", DW'(err_count), DW'(e_err));
        chk("first_err_addr", DW'(first_err_addr), DW'(e_first));
        chk("writes_issued", DW'(writes_seen), DW'(N));
        chk("reads_issued", DW'(reads_seen), DW'(N));
        chk("done_valid", DW'(udev.udev_req_valid), DW'(1'b0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1);
    end

    initial begin : main
        int           k;
        logic [N-1:0] cm;
        rst = 1'b1; start = 1'b0;
        rmode = 0; lat_max = 1; hold_en = 1'b0; cmask = '0; clr_cnt = 0; inj_cnt = 0;
        for (int i = 0; i < N; i++) ctype[i] = 0;
        repeat (2) @(posedge clk); #2;
        reset_outputs_chk("rst");
        rst = 1'b0;
        repeat (3) @(posedge clk); #2;

        // stray response while idle counts as an error with address 0
        inj_cnt++;
        repeat (4) @(posedge clk); #2;
        chk("idle_err_count", DW'(err_count), DW'(16'd1));
        chk("idle_first_err", DW'(first_err_addr), DW'(64'd0));
        chk("idle_done", DW'(done), DW'(1'b0));
        chk("idle_pass", DW'(pass), DW'(1'b0));

        start_run(0, 1, 1'b0, '0);
        finish_run();

        start_run(1, 1, 1'b0, '0);
        finish_run();

        cm = '0;
        cm[2] = 1'b1;
        start_run(0, 1, 1'b0, cm);
        finish_run();

        start_run(0, 1, 1'b1, '0);
        finish_run();
        chk("max_outstanding", DW'(max_out_seen), DW'(MAX_OUT));

        for (int r = 0; r < 5; r++) begin
            cm = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
            start_run(2, int'($urandom_range(1, 6)), 1'b0, cm);
            repeat (3) @(posedge clk); #2;
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            finish_run();
        end

        // reset while reads are outstanding
        start_run(0, 1, 1'b1, '0);
        k = 0;
        while (!(writes_seen == N && model_out == 2) && k < 500) begin
            @(sampled);
            k++;
        end
        chk("reach_two_outstanding", DW'(model_out), DW'(2));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        reset_outputs_chk("midrst");
        repeat (3) @(posedge clk); #2;
        reset_outputs_chk("midrst_hold");
        rst = 1'b0;
        repeat (2) @(posedge clk); #2;
        start_run(0, 1, 1'b0, '0);
        finish_run();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/umi_memtest_initiator.md
# umi_memtest_initiator

UMI request initiator that drives a UMI memory device, for example the UMI RAM, from the host side of the link. It sits where the simulated UMI receive and transmit endpoints normally connect: it issues requests on the device's request channel and consumes the device's responses. On `start` it writes a deterministic pattern to `N` consecutive words, reads them back with bounded outstanding reads, checks every read response, and reports the result as pass/fail, an error count and the address of the first error.

## Interface
- `DW`, 256, request/response data width
- `AW`, 64, address width
- `CW`, 32, command width
- `N`, 16, number of 32-bit words tested; legal range 1..65535
- `BASE`, 0, dstaddr of word 0; word i is at `BASE + 4*i` (AW-bit wrap)
- `RESP_ADDR`, 64'h1000, srcaddr placed in every request
- `SEED`, 32'hA5A5_0000, pattern for word i is `SEED + i` (32-bit wrap)
- `MAX_OUT`, 4, maximum outstanding reads; legal range 1..15
- `OPC_WRITE`, 8'h01; `OPC_READ`, 8'h02; `OPC_RESP`, 8'h03: opcode values

Ports:
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: asynchronous active-high reset
- `start` in 1: begin a test run when idle or done
- `busy` out 1: run in progress
- `done` out 1: run finished, held until next start
- `pass` out 1: valid when `done`; 1 iff `err_count == 0`
- `err_count` out 16: error count, saturates at 16'hFFFF
- `first_err_addr` out AW: address of first mismatching word, 0 if none
- `udev_req_valid` out 1, `udev_req_ready` in 1
- `udev_req_cmd` out CW, `udev_req_dstaddr` out AW, `udev_req_srcaddr` out AW, `udev_req_data` out DW
- `udev_resp_valid` in 1, `udev_resp_ready` out 1
- `udev_resp_cmd` in CW, `udev_resp_dstaddr` in AW, `udev_resp_srcaddr` in AW, `udev_resp_data` in DW

## Operation
- Command layout: `cmd[7:0]` opcode, `cmd[11:8]` size = 2 (4 bytes), all other bits 0.
- Write request: opcode `OPC_WRITE`, `data` is the 32-bit pattern replicated DW/32 times. Writes are posted and get no response.
- Read request: opcode `OPC_READ`, `data` = 0. Both request types carry `srcaddr = RESP_ADDR`.
- FSM states:
  - IDLE: wait for `start`, then WRITE.
  - WRITE: issue writes i = 0..N-1. After the handshake of write N-1, go to READ.
  - READ: issue reads i = 0..N-1 while `outstanding < MAX_OUT`. After the handshake of read N-1, go to DRAIN.
  - DRAIN: wait for `outstanding == 0`, then DONE.
  - DONE: `done = 1`. `start` clears all counters and status and goes to WRITE.
- `start` is ignored in WRITE, READ and DRAIN.
- Request channel: a request is transferred on a cycle with `valid && ready`. Once `udev_req_valid` rises, `valid` and the whole payload stay unchanged until the handshake. The next request can be presented in the cycle after the handshake (back-to-back allowed).
- `outstanding` counter: +1 on a read handshake, -1 on a response handshake. If both happen in the same cycle it is unchanged.
- `udev_resp_ready` = 1 in every state after reset.
- Responses are in order. The expected index `ridx` increments on every response handshake in READ or DRAIN.
- A response is correct iff all of:
  - opcode is `OPC_RESP`
  - `dstaddr == RESP_ADDR`
  - `data[31:0] == SEED + ridx`
- An incorrect response, or any response in IDLE, WRITE or DONE, increments `err_count`. A response in these states does not change `ridx` or `outstanding`.
- `first_err_addr` is loaded with `BASE + 4*ridx` on the first mismatch of the run. For an unexpected response it is loaded with 0.

## Timing
- Reset (asynchronous): state IDLE; every output 0, including `udev_resp_ready` while `rst` is high; all counters 0.
- `start` sampled high in IDLE/DONE at edge t: `busy = 1` and `udev_req_valid = 1` with write 0 from t+1.
- Handshake at edge t: the next request is valid from t+1, or `valid` drops if the FSM is stalled or leaving the state.
- READ when `outstanding == MAX_OUT`: `udev_req_valid = 0` until a response handshake. Valid returns the cycle after that handshake.
- Response in the same cycle as the last read handshake: counted correctly.
- DONE at t+1 after the edge where DRAIN sees `outstanding == 0`. `busy` falls and `done`/`pass` rise in the same cycle.
- Minimum run with zero-latency device: 2N request cycles plus device read latency plus 2.
- Reset mid-run: immediate return to reset values; no partial state survives.

## Test plan
- N=4, default SEED, ideal RAM model (ready=1, 1-cycle read latency) -> 4 writes to 0,4,8,12 with data 0xA5A50000..0xA5A50003, then 4 reads; `done=1`, `pass=1`, `err_count=0`.
- Same run with `udev_req_ready` toggling every other cycle -> payload stable while stalled; no duplicate or missing requests; `pass=1`.
- Model corrupts the read data of word 2 -> `err_count=1`, `first_err_addr=BASE+8`, `pass=0`.
- Model holds responses for 20 cycles, MAX_OUT=4, N=8 -> exactly 4 reads issued, then `udev_req_valid=0` until the first response; `pass=1`.
- Unexpected response injected in IDLE -> `err_count=1`; a following `start` clears it and a clean run ends with `pass=1`.
- `rst` pulsed in READ with 2 reads outstanding -> all outputs 0 during reset; a new `start` after flushing the model completes with `pass=1`.
